// File: rtl/alu_arbiter_if.sv
// One requester channel of the shared-ALU arbiter: request handshake plus
// the held response slot returned to that requester.
interface alu_arbiter_if #(
    parameter int unsigned RISCV_WORD_WIDTH = 32,
    parameter int unsigned ALU_OP_WIDTH     = 4
);
    logic                        req_valid;
    logic                        req_ready;
    logic [ALU_OP_WIDTH-1:0]     req_op;
    logic [RISCV_WORD_WIDTH-1:0] req_a;
    logic [RISCV_WORD_WIDTH-1:0] req_b;
    logic                        rsp_valid;
    logic                        rsp_ready;
    logic [RISCV_WORD_WIDTH-1:0] rsp_result;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_result
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_result
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters,
// each with a single registered response slot.
module alu_arbiter #(
    parameter int unsigned             RISCV_WORD_WIDTH = 32,
    parameter int unsigned             ALU_OP_WIDTH     = 4,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_PASS         = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    alu_arbiter_if.slave                req0_bus,
    alu_arbiter_if.slave                req1_bus,
    output logic [ALU_OP_WIDTH-1:0]     alu_op_o,
    output logic [RISCV_WORD_WIDTH-1:0] alu_operand_a_o,
    output logic [RISCV_WORD_WIDTH-1:0] alu_operand_b_o,
    input  logic [RISCV_WORD_WIDTH-1:0] alu_result_i
);

    logic                        r_ptr;
    logic [1:0]                  r_rsp_valid;
    logic [RISCV_WORD_WIDTH-1:0] r_rsp_result0;
    logic [RISCV_WORD_WIDTH-1:0] r_rsp_result1;

    logic [1:0] w_req_valid;
    logic [1:0] w_rsp_ready;
    logic [1:0] w_elig;
    logic [1:0] w_gnt;

    assign w_req_valid = {req1_bus.req_valid, req0_bus.req_valid};
    assign w_rsp_ready = {req1_bus.rsp_ready, req0_bus.rsp_ready};

    // A slot that drains this cycle can take a new result at the same edge.
    always_comb begin
        w_elig = w_req_valid & (~r_rsp_valid | w_rsp_ready);
        w_gnt  = 2'b00;
        if (!rst_i) begin
            if (&w_elig) begin
                w_gnt[r_ptr] = 1'b1;
            end else begin
                w_gnt = w_elig;
            end
        end
    end

    always_comb begin
        alu_op_o        = ALU_PASS;
        alu_operand_a_o = '0;
        alu_operand_b_o = '0;
        if (w_gnt[0]) begin
            alu_op_o        = req0_bus.req_op;
            alu_operand_a_o = req0_bus.req_a;
            alu_operand_b_o = req0_bus.req_b;
        end else if (w_gnt[1]) begin
            alu_op_o        = req1_bus.req_op;
            alu_operand_a_o = req1_bus.req_a;
            alu_operand_b_o = req1_bus.req_b;
        end
    end

    // Pointer points away from the port just served; grant beats drain.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr         <= 1'b0;
            r_rsp_valid   <= 2'b00;
            r_rsp_result0 <= '0;
            r_rsp_result1 <= '0;
        end else begin
            if (|w_gnt) begin
                r_ptr <= w_gnt[0];
            end
            if (w_gnt[0]) begin
                r_rsp_valid[0] <= 1'b1;
                r_rsp_result0  <= alu_result_i;
            end else if (w_rsp_ready[0]) begin
                r_rsp_valid[0] <= 1'b0;
            end
            if (w_gnt[1]) begin
                r_rsp_valid[1] <= 1'b1;
                r_rsp_result1  <= alu_result_i;
            end else if (w_rsp_ready[1]) begin
                r_rsp_valid[1] <= 1'b0;
            end
        end
    end

    assign req0_bus.req_ready  = w_gnt[0];
    assign req1_bus.req_ready  = w_gnt[1];
    assign req0_bus.rsp_valid  = r_rsp_valid[0];
    assign req1_bus.rsp_valid  = r_rsp_valid[1];
    assign req0_bus.rsp_result = r_rsp_result0;
    assign req1_bus.rsp_result = r_rsp_result1;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU and
// per-port scoreboards checked by an independent response monitor.
module tb_alu_arbiter;

    localparam int unsigned W   = 32;
    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_PASS = 4'd0;
    localparam logic [OPW-1:0] OP_ADD  = 4'd1;
    localparam logic [OPW-1:0] OP_SUB  = 4'd2;
    localparam logic [OPW-1:0] OP_XOR  = 4'd3;
    localparam logic [OPW-1:0] OP_OR   = 4'd4;

    logic           clk;
    logic           rst;
    logic [OPW-1:0] alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic [W-1:0]   alu_result;

    alu_arbiter_if #(.RISCV_WORD_WIDTH(W), .ALU_OP_WIDTH(OPW)) bus0 ();
    alu_arbiter_if #(.RISCV_WORD_WIDTH(W), .ALU_OP_WIDTH(OPW)) bus1 ();

    alu_arbiter #(
        .RISCV_WORD_WIDTH(W),
        .ALU_OP_WIDTH    (OPW),
        .ALU_PASS        (OP_PASS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req0_bus       (bus0),
        .req1_bus       (bus1),
        .alu_op_o       (alu_op),
        .alu_operand_a_o(alu_a),
        .alu_operand_b_o(alu_b),
        .alu_result_i   (alu_result)
    );

    // Shared combinational ALU
    always_comb begin
        case (alu_op)
            OP_ADD:  alu_result = alu_a + alu_b;
            OP_SUB:  alu_result = alu_a - alu_b;
            OP_XOR:  alu_result = alu_a ^ alu_b;
            OP_OR:   alu_result = alu_a | alu_b;
            default: alu_result = alu_a;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    logic [W-1:0] exp0[$];
    logic [W-1:0] exp1[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Response monitor: every consumed result is matched against the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus0.rsp_valid && bus0.rsp_ready) begin
                    if (exp0.size() == 0) begin
                        n_total++;
                        $display("FAIL rsp0_unexpected: got 0x%0h expected none", bus0.rsp_result);
                    end else begin
                        chk("rsp0_result", bus0.rsp_result, exp0.pop_front());
                    end
                end
                if (bus1.rsp_valid && bus1.rsp_ready) begin
                    if (exp1.size() == 0) begin
                        n_total++;
                        $display("FAIL rsp1_unexpected: got 0x%0h expected none", bus1.rsp_result);
                    end else begin
                        chk("rsp1_result", bus1.rsp_result, exp1.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus0.req_valid = v; bus0.req_op = op; bus0.req_a = a; bus0.req_b = b;
    endtask

    task automatic drive1(input logic v, input logic [OPW-1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus1.req_valid = v; bus1.req_op = op; bus1.req_a = a; bus1.req_b = b;
    endtask

    initial begin
        rst = 1'b1;
        drive0(1'b1, OP_ADD, 32'd1, 32'd1);
        drive1(1'b0, OP_PASS, '0, '0);
        bus0.rsp_ready = 1'b1;
        bus1.rsp_ready = 1'b1;

        // Reset: no grant, idle ALU even with a request pending
        cyc();
        @(negedge clk);
        chk("rst_ready0", 32'(bus0.req_ready), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'(OP_PASS));
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_rsp0_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("rst_rsp1_valid", 32'(bus1.rsp_valid), 32'd0);
        cyc();
        rst = 1'b0;
        drive0(1'b0, OP_PASS, '0, '0);

        // Single op on port 0
        cyc();
        drive0(1'b1, OP_ADD, 32'd5, 32'd7);
        @(negedge clk);
        chk("single_ready0", 32'(bus0.req_ready), 32'd1);
        chk("single_ready1", 32'(bus1.req_ready), 32'd0);
        chk("single_alu_op", 32'(alu_op), 32'(OP_ADD));
        chk("single_alu_a", alu_a, 32'd5);
        chk("single_alu_b", alu_b, 32'd7);
        exp0.push_back(32'd12);
        cyc();
        drive0(1'b0, OP_PASS, '0, '0);
        @(negedge clk);
        chk("single_rsp0_valid", 32'(bus0.rsp_valid), 32'd1);
        chk("single_rsp1_valid", 32'(bus1.rsp_valid), 32'd0);

        // Contention from a fresh reset: grants alternate 0,1,0,1
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        drive0(1'b1, OP_SUB, 32'd10, 32'd3);
        drive1(1'b1, OP_XOR, 32'hF0, 32'h0F);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_ready0", 32'(bus0.req_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_ready1", 32'(bus1.req_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) exp0.push_back(32'd7);
            else            exp1.push_back(32'hFF);
            cyc();
        end
        drive0(1'b0, OP_PASS, '0, '0);
        drive1(1'b0, OP_PASS, '0, '0);
        bus1.rsp_ready = 1'b0;
        @(negedge clk);
        chk("bp_rsp1_full", 32'(bus1.rsp_valid), 32'd1);

        // Backpressure on port 1 does not block port 0
        cyc();
        drive0(1'b1, OP_ADD, 32'd2, 32'd3);
        drive1(1'b1, OP_ADD, 32'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready1", 32'(bus1.req_ready), 32'd0);
            chk("bp_ready0", 32'(bus0.req_ready), 32'd1);
            chk("bp_rsp1_hold", bus1.rsp_result, 32'hFF);
            exp0.push_back(32'd5);
            cyc();
        end
        drive0(1'b0, OP_PASS, '0, '0);
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready1", 32'(bus1.req_ready), 32'd1);
        exp1.push_back(32'd2);
        cyc();
        drive1(1'b0, OP_PASS, '0, '0);
        @(negedge clk);
        chk("bp_rsp1_valid", 32'(bus1.rsp_valid), 32'd1);

        // Drain-and-refill on port 0
        cyc();
        bus0.rsp_ready = 1'b0;
        drive0(1'b1, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        chk("dr_fill_ready0", 32'(bus0.req_ready), 32'd1);
        exp0.push_back(32'd2);
        cyc();
        bus0.rsp_ready = 1'b1;
        drive0(1'b1, OP_OR, 32'h1, 32'h2);
        @(negedge clk);
        chk("dr_refill_ready0", 32'(bus0.req_ready), 32'd1);
        chk("dr_refill_valid", 32'(bus0.rsp_valid), 32'd1);
        exp0.push_back(32'h3);
        cyc();
        drive0(1'b0, OP_PASS, '0, '0);
        @(negedge clk);
        chk("dr_valid_kept", 32'(bus0.rsp_valid), 32'd1);
        chk("dr_result", bus0.rsp_result, 32'h3);
        cyc();
        @(negedge clk);
        chk("dr_drained", 32'(bus0.rsp_valid), 32'd0);

        // Reset mid-operation: pointer left at 1 and rsp1 full beforehand
        cyc();
        bus1.rsp_ready = 1'b0;
        drive1(1'b1, OP_ADD, 32'd4, 32'd4);
        @(negedge clk);
        chk("rm_fill_ready1", 32'(bus1.req_ready), 32'd1);
        cyc();
        drive1(1'b0, OP_PASS, '0, '0);
        drive0(1'b1, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        chk("rm_ready0", 32'(bus0.req_ready), 32'd1);
        exp0.push_back(32'd2);
        cyc();
        drive0(1'b0, OP_PASS, '0, '0);
        @(negedge clk);
        chk("rm_rsp1_full", 32'(bus1.rsp_valid), 32'd1);
        cyc();
        rst = 1'b1;
        bus1.rsp_ready = 1'b1;
        drive0(1'b1, OP_ADD, 32'd1, 32'd2);
        drive1(1'b1, OP_ADD, 32'd1, 32'd1);
        @(negedge clk);
        chk("rm_rst_ready0", 32'(bus0.req_ready), 32'd0);
        chk("rm_rst_ready1", 32'(bus1.req_ready), 32'd0);
        chk("rm_rst_alu_op", 32'(alu_op), 32'(OP_PASS));
        cyc();
        rst = 1'b0;
        @(negedge clk);
        chk("rm_rsp0_cleared", 32'(bus0.rsp_valid), 32'd0);
        chk("rm_rsp1_cleared", 32'(bus1.rsp_valid), 32'd0);
        chk("rm_ptr_ready0", 32'(bus0.req_ready), 32'd1);
        chk("rm_ptr_ready1", 32'(bus1.req_ready), 32'd0);
        exp0.push_back(32'd3);
        cyc();
        drive0(1'b0, OP_PASS, '0, '0);
        drive1(1'b0, OP_PASS, '0, '0);

        // Idle cycles leave the ALU at PASS/0/0 and the pointer where it was
        for (int i = 0; i < 3; i++) begin
            cyc();
            @(negedge clk);
            chk("idle_alu_op", 32'(alu_op), 32'(OP_PASS));
            chk("idle_alu_a", alu_a, 32'd0);
            chk("idle_alu_b", alu_b, 32'd0);
        end
        cyc();
        drive0(1'b1, OP_ADD, 32'd9, 32'd9);
        drive1(1'b1, OP_ADD, 32'd6, 32'd7);
        @(negedge clk);
        chk("idle_ptr_ready1", 32'(bus1.req_ready), 32'd1);
        chk("idle_ptr_ready0", 32'(bus0.req_ready), 32'd0);
        chk("idle_ptr_alu_a", alu_a, 32'd6);
        exp1.push_back(32'd13);
        cyc();
        drive0(1'b0, OP_PASS, '0, '0);
        drive1(1'b0, OP_PASS, '0, '0);

        repeat (3) cyc();
        chk("exp0_drained", 32'(exp0.size()), 32'd0);
        chk("exp1_drained", 32'(exp1.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RISCV_WORD_WIDTH, default 32, operand/result width, taken from the RISC-V defines.
REQ-002 Parameter: ALU_OP_WIDTH, default from the ALU defines, width of the ALU operation code.
REQ-003 Port: clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_i  input  1  reset, synchronous, active-high.
REQ-005 Ports (k = 0,1): reqk_valid_i  input  1  requester k presents an operation.
REQ-006 Ports (k = 0,1): reqk_ready_o  output  1  operation k accepted this cycle.
REQ-007 Ports (k = 0,1): reqk_op_i  input  ALU_OP_WIDTH  ALU operation code.
REQ-008 Ports (k = 0,1): reqk_a_i, reqk_b_i  input  RISCV_WORD_WIDTH  operands A and B.
REQ-009 Ports (k = 0,1): rspk_valid_o  output  1  result for requester k is held.
REQ-010 Ports (k = 0,1): rspk_ready_i  input  1  requester k consumes the result.
REQ-011 Ports (k = 0,1): rspk_result_o  output  RISCV_WORD_WIDTH  result for requester k.
REQ-012 Port: alu_op_o  output  ALU_OP_WIDTH  operation code driven to the shared combinational ALU.
REQ-013 Port: alu_operand_a_o, alu_operand_b_o  output  RISCV_WORD_WIDTH  operands to the shared ALU.
REQ-014 Port: alu_result_i  input  RISCV_WORD_WIDTH  combinational result from the shared ALU.

Function
REQ-015 The block SHALL share one combinational ALU between two requesters, one operation per cycle at most.
REQ-016 Requester k SHALL be eligible when reqk_valid_i=1 and its response slot is empty or is being drained this cycle (rspk_valid_o=1 and rspk_ready_i=1).
REQ-017 Exactly one eligible requester SHALL be granted per cycle; with one eligible, it wins unconditionally.
REQ-018 With both eligible, the requester indicated by a 1-bit round-robin pointer SHALL win.
REQ-019 After every grant to port k, the pointer SHALL move to the other port; with no grant, the pointer SHALL hold.
REQ-020 reqk_ready_o SHALL be 1 only in the cycle requester k is granted; it is combinational from valid inputs and state.
REQ-021 In a grant cycle, alu_op_o/alu_operand_a_o/alu_operand_b_o SHALL equal the granted requester's op/a/b in the same cycle.
REQ-022 With no grant, the ALU outputs SHALL drive ALU_PASS with both operands 0.
REQ-023 On a grant to k at edge N, alu_result_i SHALL be captured into rspk_result_o and rspk_valid_o set to 1 after edge N (latency 1 cycle).
REQ-024 rspk_result_o SHALL remain stable while rspk_valid_o=1 and rspk_ready_i=0.
REQ-025 rspk_valid_o SHALL clear at an edge where rspk_ready_i=1, unless a new grant to k is accepted in that cycle, in which case valid stays 1 and the new result loads (back-to-back, full throughput per port).
REQ-026 A requester SHALL hold valid and payload stable until ready; the block does not buffer unaccepted requests.
REQ-027 Responses SHALL be returned in order per port; the two ports are independent (a stalled rsp0 never blocks port 1).
REQ-028 No combinational path SHALL exist from rspk_ready_i to rspk_valid_o or rspk_result_o.

Reset
REQ-029 While rst_i=1 at a rising edge: rsp0_valid_o=rsp1_valid_o=0, rsp results = 0, pointer = port 0.
REQ-030 Reset SHALL take priority over any grant or drain in the same cycle; an operation accepted in that cycle is discarded.
REQ-031 During reset, reqk_ready_o SHALL be 0 and the ALU outputs SHALL be idle (ALU_PASS, 0, 0).

Verification
REQ-032 Single op: req0 ALU_ADD a=5 b=7, rsp0_ready_i=1 -> req0_ready_o=1 same cycle; rsp0_valid_o=1, rsp0_result_o=12 next cycle; rsp1_valid_o stays 0.
REQ-033 Contention: both valid every cycle for 4 cycles (req0 ALU_SUB 10,3; req1 ALU_XOR 0xF0,0x0F), both rsp ready -> grants 0,1,0,1 after reset; results 7 and 0xFF alternate.
REQ-034 Backpressure: rsp1_ready_i=0 with rsp1 full, req1 valid -> req1_ready_o=0, rsp1_result_o unchanged; req0 still granted each cycle.
REQ-035 Drain-and-refill: rsp0 full, rsp0_ready_i=1 and req0 valid with ALU_OR 0x1,0x2 -> grant same cycle, rsp0_valid_o stays 1, result becomes 0x3.
REQ-036 Reset mid-operation: rst_i=1 in a grant cycle with rsp1 full -> after edge both rsp valids 0, next simultaneous request grants port 0.
REQ-037 Idle: no valids for 3 cycles -> alu_op_o=ALU_PASS, operands 0, pointer unchanged.
